// File: rtl/rob_buffer.sv
// -----------------------------------------------------------------------------
// rob_pkg / rob_buffer
//
// In-order reorder buffer.
//   * Dispatch allocates one entry per cycle at the tail.
//   * Execution units complete entries by slot index.
//   * The commit stage retires one entry per cycle from the head.
//   * Retiring an entry whose status is not DONE flushes the whole buffer.
//     On the next cycle flush_out pulses for one cycle and redirect_pc_out
//     carries the faulting entry's next_pc.
//
// Ports
//   clk_in, rst_in           : clock, synchronous active-high reset
//   alloc_valid_in/_entry_in : dispatch offer (entry status field ignored)
//   alloc_ready_out          : buffer not full
//   alloc_idx_out            : slot the next accepted entry will occupy
//   wb_valid_in/_idx_in/_status_in : completion report
//   commit_valid_out/_entry_out/_idx_out, commit_ready_in : retire handshake
//   flush_out, redirect_pc_out : registered flush pulse and redirect target
//   count_out, empty_out, full_out : occupancy
// -----------------------------------------------------------------------------
package rob_pkg;
    localparam int ADDR_BITS   = 32;
    localparam int ROB_ENTRIES = 256;

    typedef enum logic [2:0] {
        ISSUED    = 3'd0,
        DONE      = 3'd1,
        EXCEPTION = 3'd2,
        INTERRUPT = 3'd3,
        TRAP      = 3'd4
    } status_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] pc;
        logic [ADDR_BITS-1:0] next_pc;
        logic [4:0]           dest;
        status_t              status;
    } rob_entry;
endpackage

module rob_buffer #(
    parameter int ENTRIES = rob_pkg::ROB_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            alloc_valid_in,
    input  rob_pkg::rob_entry               alloc_entry_in,
    output logic                            alloc_ready_out,
    output logic [IDX_W-1:0]                alloc_idx_out,
    input  logic                            wb_valid_in,
    input  logic [IDX_W-1:0]                wb_idx_in,
    input  rob_pkg::status_t                wb_status_in,
    output logic                            commit_valid_out,
    output rob_pkg::rob_entry               commit_entry_out,
    output logic [IDX_W-1:0]                commit_idx_out,
    input  logic                            commit_ready_in,
    output logic                            flush_out,
    output logic [rob_pkg::ADDR_BITS-1:0]   redirect_pc_out,
    output logic [IDX_W:0]                  count_out,
    output logic                            empty_out,
    output logic                            full_out
);
    import rob_pkg::*;

    localparam int CNT_W = IDX_W + 1;

    // Payload storage: written only on allocate, never reset. The live status
    // of each slot is kept separately so writebacks don't touch the payload.
    rob_entry          data_mem [ENTRIES];
    logic              valid_reg [ENTRIES];
    status_t           status_reg [ENTRIES];

    logic [IDX_W-1:0]  head_reg, head_next;
    logic [IDX_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              flush_reg;
    logic [ADDR_BITS-1:0] redirect_reg;

    logic              full;
    logic              alloc_fire;
    logic              retire_fire;
    logic              flush_fire;
    logic              done_retire;
    logic              wb_hit;
    status_t           head_status;

    // ---------------------------------------------------------------- decode
    assign full        = (count_reg == CNT_W'(ENTRIES));
    assign head_status = status_reg[head_reg];

    assign commit_valid_out = valid_reg[head_reg] && (head_status != ISSUED);
    assign retire_fire      = commit_valid_out && commit_ready_in;
    assign flush_fire       = retire_fire && (head_status != DONE);
    assign done_retire      = retire_fire && !flush_fire;

    // A flush discards any allocation offered in the same cycle.
    assign alloc_fire = alloc_valid_in && !full && !flush_fire;

    // First completion report wins; later reports and ISSUED reports are
    // dropped, as is anything arriving while the buffer is being flushed.
    assign wb_hit = wb_valid_in && !flush_fire && (wb_status_in != ISSUED)
                    && valid_reg[wb_idx_in] && (status_reg[wb_idx_in] == ISSUED);

    // ---------------------------------------------------------- pointer logic
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_fire) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (alloc_fire) begin
                tail_next = tail_reg + IDX_W'(1);
            end
            if (done_retire) begin
                head_next = head_reg + IDX_W'(1);
            end
            // Allocate and retire together leave the occupancy unchanged.
            case ({alloc_fire, done_retire})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            flush_reg    <= 1'b0;
            redirect_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            flush_reg <= flush_fire;
            if (flush_fire) begin
                redirect_reg <= data_mem[head_reg].next_pc;
            end
        end
    end

    // ------------------------------------------------------------ payload RAM
    always_ff @(posedge clk_in) begin
        if (!rst_in && alloc_fire) begin
            data_mem[tail_reg] <= alloc_entry_in;
        end
    end

    // ------------------------------------------------------- per-slot state
    // Allocation only targets an invalid slot and writeback only a valid one,
    // and the head is only equal to the tail while allocating when empty, so
    // the set/clear conditions below never collide on the same slot.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
        always_ff @(posedge clk_in) begin
            if (rst_in || flush_fire) begin
                valid_reg[gi] <= 1'b0;
            end else if (alloc_fire && (tail_reg == IDX_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end else if (done_retire && (head_reg == IDX_W'(gi))) begin
                valid_reg[gi] <= 1'b0;
            end
        end

        // Status needs no reset: it is only observed through a set valid bit,
        // and every allocation re-initialises it to ISSUED.
        always_ff @(posedge clk_in) begin
            if (!rst_in) begin
                if (alloc_fire && (tail_reg == IDX_W'(gi))) begin
                    status_reg[gi] <= ISSUED;
                end else if (wb_hit && (wb_idx_in == IDX_W'(gi))) begin
                    status_reg[gi] <= wb_status_in;
                end
            end
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        commit_entry_out        = data_mem[head_reg];
        commit_entry_out.status = status_reg[head_reg];
    end

    assign commit_idx_out  = head_reg;
    assign alloc_idx_out   = tail_reg;
    assign alloc_ready_out = !full;
    assign count_out       = count_reg;
    assign empty_out       = (count_reg == '0);
    assign full_out        = full;
    assign flush_out       = flush_reg;
    assign redirect_pc_out = redirect_reg;

endmodule

// File: tb/tb_rob_buffer.sv
// -----------------------------------------------------------------------------
// tb_rob_buffer
//
// Self-checking bench for rob_buffer with ENTRIES=4. Every cycle is compared
// against a queue-based reference model; a vector table, hand-written corner
// sequences and a randomized run supply the stimulus.
// -----------------------------------------------------------------------------
module tb_rob_buffer;
    import rob_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_valid;
    rob_entry             alloc_entry;
    logic                 alloc_ready;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 wb_valid;
    logic [IDX_W-1:0]     wb_idx;
    status_t              wb_status;
    logic                 commit_valid;
    rob_entry             commit_entry;
    logic [IDX_W-1:0]     commit_idx;
    logic                 commit_ready;
    logic                 flush;
    logic [ADDR_BITS-1:0] redirect_pc;
    logic [IDX_W:0]       count;
    logic                 empty;
    logic                 full;

    always #5 clk = ~clk;

    rob_buffer #(.ENTRIES(N)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .alloc_valid_in  (alloc_valid),
        .alloc_entry_in  (alloc_entry),
        .alloc_ready_out (alloc_ready),
        .alloc_idx_out   (alloc_idx),
        .wb_valid_in     (wb_valid),
        .wb_idx_in       (wb_idx),
        .wb_status_in    (wb_status),
        .commit_valid_out(commit_valid),
        .commit_entry_out(commit_entry),
        .commit_idx_out  (commit_idx),
        .commit_ready_in (commit_ready),
        .flush_out       (flush),
        .redirect_pc_out (redirect_pc),
        .count_out       (count),
        .empty_out       (empty),
        .full_out        (full)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ------------------------------------------------------ reference model
    // The buffer is an ordered list of in-flight entries, oldest first; each
    // remembers the slot number it was given at allocation.
    typedef struct {
        rob_entry e;
        int       idx;
    } item_t;

    item_t                mq[$];
    int                   m_tail     = 0;
    bit                   m_flush    = 0;
    logic [ADDR_BITS-1:0] m_redirect = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit av, input rob_entry e, input bit wv,
                                input int wi, input status_t ws, input bit rdy);
        bit    retire;
        bit    flushing;
        bit    accept;
        item_t it;
        if (r) begin
            mq.delete();
            m_tail     = 0;
            m_flush    = 0;
            m_redirect = '0;
            return;
        end
        retire   = (mq.size() > 0) && (mq[0].e.status != ISSUED) && rdy;
        flushing = retire && (mq[0].e.status != DONE);
        accept   = av && (mq.size() < N);
        if (flushing) begin
            m_redirect = mq[0].e.next_pc;
            mq.delete();
            m_tail  = 0;
            m_flush = 1;
        end else begin
            m_flush = 0;
            if (wv && ws != ISSUED) begin
                foreach (mq[i]) begin
                    if (mq[i].idx == wi && mq[i].e.status == ISSUED) begin
                        it          = mq[i];
                        it.e.status = ws;
                        mq[i]       = it;
                    end
                end
            end
            if (retire) void'(mq.pop_front());
            if (accept) begin
                it.e        = e;
                it.e.status = ISSUED;
                it.idx      = m_tail;
                mq.push_back(it);
                m_tail = (m_tail + 1) % N;
            end
        end
    endtask

    task automatic model_check();
        int sz;
        int head;
        bit cv;
        sz   = mq.size();
        head = (m_tail - sz + N) % N;
        cv   = (sz > 0) && (mq[0].e.status != ISSUED);
        chk("m_count",       64'(count),        64'(sz));
        chk("m_empty",       64'(empty),        64'(sz == 0));
        chk("m_full",        64'(full),         64'(sz == N));
        chk("m_alloc_ready", 64'(alloc_ready),  64'(sz < N));
        chk("m_alloc_idx",   64'(alloc_idx),    64'(m_tail));
        chk("m_commit_idx",  64'(commit_idx),   64'(head));
        chk("m_commit_valid",64'(commit_valid), 64'(cv));
        chk("m_flush",       64'(flush),        64'(m_flush));
        if (cv) begin
            chk("m_commit_pc",     64'(commit_entry.pc),      64'(mq[0].e.pc));
            chk("m_commit_nextpc", 64'(commit_entry.next_pc), 64'(mq[0].e.next_pc));
            chk("m_commit_dest",   64'(commit_entry.dest),    64'(mq[0].e.dest));
            chk("m_commit_status", 64'(commit_entry.status),  64'(mq[0].e.status));
        end
        if (m_flush) chk("m_redirect", 64'(redirect_pc), 64'(m_redirect));
    endtask

    // One transaction = one clock: drive, clock, update model, sample, check.
    task automatic step(input bit r, input bit av, input rob_entry e, input bit wv,
                        input int wi, input status_t ws, input bit rdy);
        rst          = r;
        alloc_valid  = av;
        alloc_entry  = e;
        wb_valid     = wv;
        wb_idx       = wi[IDX_W-1:0];
        wb_status    = ws;
        commit_ready = rdy;
        @(posedge clk);
        model_update(r, av, e, wv, wi, ws, rdy);
        @(negedge clk);
        cyc++;
        $display("cyc %0d rst=%0b alloc=%0b pc=%h wb=%0b idx=%0d st=%s rdy=%0b -> cnt=%0d cv=%0b cidx=%0d aidx=%0d flush=%0b",
                 cyc, r, av, e.pc, wv, wi, ws.name(), rdy, count, commit_valid, commit_idx, alloc_idx, flush);
        model_check();
    endtask

    function automatic rob_entry mk(input logic [31:0] pc, input logic [31:0] npc);
        rob_entry e;
        e.pc      = pc;
        e.next_pc = npc;
        e.dest    = pc[6:2];
        e.status  = DONE;   // must be overridden to ISSUED by the buffer
        return e;
    endfunction

    task automatic idle(input bit rdy);
        step(0, 0, mk(0, 0), 0, 0, DONE, rdy);
    endtask

    task automatic check_reset_values();
        chk("rst_count",       64'(count),        64'd0);
        chk("rst_empty",       64'(empty),        64'd1);
        chk("rst_full",        64'(full),         64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready),  64'd1);
        chk("rst_commit_valid",64'(commit_valid), 64'd0);
        chk("rst_alloc_idx",   64'(alloc_idx),    64'd0);
        chk("rst_commit_idx",  64'(commit_idx),   64'd0);
        chk("rst_flush",       64'(flush),        64'd0);
        chk("rst_redirect",    64'(redirect_pc),  64'd0);
    endtask

    // ------------------------------------------------------------- vectors
    typedef struct {
        bit          av;
        logic [31:0] pc;
        bit          wv;
        int          wi;
        status_t     ws;
        bit          rdy;
        int          ecount;
        bit          ecv;
        int          ecidx;
        int          eaidx;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[20];

    function automatic status_t rand_status();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)  return DONE;
        if (r == 6) return EXCEPTION;
        if (r == 7) return INTERRUPT;
        if (r == 8) return TRAP;
        return ISSUED;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill / drain
        tbl[0]  = '{1, 32'h100, 0, 0, DONE, 0,  1, 0, 0, 1, 32'h0};
        tbl[1]  = '{1, 32'h104, 0, 0, DONE, 0,  2, 0, 0, 2, 32'h0};
        tbl[2]  = '{1, 32'h108, 0, 0, DONE, 0,  3, 0, 0, 3, 32'h0};
        tbl[3]  = '{1, 32'h10C, 0, 0, DONE, 0,  4, 0, 0, 0, 32'h0};
        tbl[4]  = '{1, 32'h110, 0, 0, DONE, 0,  4, 0, 0, 0, 32'h0};   // refused: full
        tbl[5]  = '{0, 32'h0,   1, 0, DONE, 0,  4, 1, 0, 0, 32'h100};
        tbl[6]  = '{0, 32'h0,   1, 1, DONE, 0,  4, 1, 0, 0, 32'h100};
        tbl[7]  = '{0, 32'h0,   1, 2, DONE, 1,  3, 1, 1, 0, 32'h104};
        tbl[8]  = '{0, 32'h0,   1, 3, DONE, 1,  2, 1, 2, 0, 32'h108};
        tbl[9]  = '{0, 32'h0,   0, 0, DONE, 1,  1, 1, 3, 0, 32'h10C};
        tbl[10] = '{0, 32'h0,   0, 0, DONE, 1,  0, 0, 0, 0, 32'h0};
        // Out-of-order completion
        tbl[11] = '{1, 32'h200, 0, 0, DONE, 0,  1, 0, 0, 1, 32'h0};
        tbl[12] = '{1, 32'h204, 0, 0, DONE, 0,  2, 0, 0, 2, 32'h0};
        tbl[13] = '{1, 32'h208, 0, 0, DONE, 0,  3, 0, 0, 3, 32'h0};
        tbl[14] = '{0, 32'h0,   1, 2, DONE, 1,  3, 0, 0, 3, 32'h0};
        tbl[15] = '{0, 32'h0,   1, 1, DONE, 1,  3, 0, 0, 3, 32'h0};
        tbl[16] = '{0, 32'h0,   1, 0, DONE, 1,  3, 1, 0, 3, 32'h200};
        tbl[17] = '{0, 32'h0,   0, 0, DONE, 1,  2, 1, 1, 3, 32'h204};
        tbl[18] = '{0, 32'h0,   0, 0, DONE, 1,  1, 1, 2, 3, 32'h208};
        tbl[19] = '{0, 32'h0,   0, 0, DONE, 1,  0, 0, 3, 3, 32'h0};

        rst = 1; alloc_valid = 0; alloc_entry = '0; wb_valid = 0; wb_idx = '0;
        wb_status = DONE; commit_ready = 0;

        step(1, 0, mk(0, 0), 0, 0, DONE, 0);
        check_reset_values();

        for (int i = 0; i < 20; i++) begin
            step(0, tbl[i].av, mk(tbl[i].pc, tbl[i].pc + 4), tbl[i].wv, tbl[i].wi, tbl[i].ws, tbl[i].rdy);
            chk($sformatf("tbl%0d_count", i),   64'(count),        64'(tbl[i].ecount));
            chk($sformatf("tbl%0d_cvalid", i),  64'(commit_valid), 64'(tbl[i].ecv));
            chk($sformatf("tbl%0d_cidx", i),    64'(commit_idx),   64'(tbl[i].ecidx));
            chk($sformatf("tbl%0d_aidx", i),    64'(alloc_idx),    64'(tbl[i].eaidx));
            chk($sformatf("tbl%0d_full", i),    64'(full),         64'(tbl[i].ecount == N));
            chk($sformatf("tbl%0d_aready", i),  64'(alloc_ready),  64'(tbl[i].ecount != N));
            if (tbl[i].ecv) chk($sformatf("tbl%0d_pc", i), 64'(commit_entry.pc), 64'(tbl[i].epc));
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // Exception flush
        step(1, 0, mk(0, 0), 0, 0, DONE, 0);
        check_reset_values();
        step(0, 1, mk(32'h300, 32'h304), 0, 0, DONE, 0);
        step(0, 1, mk(32'h304, 32'h8000_0000), 0, 0, DONE, 0);
        step(0, 1, mk(32'h308, 32'h30C), 0, 0, DONE, 0);
        step(0, 0, mk(0, 0), 1, 1, EXCEPTION, 0);
        step(0, 0, mk(0, 0), 1, 0, DONE, 0);
        step(0, 0, mk(0, 0), 0, 0, DONE, 1);           // idx0 retires as DONE
        chk("exc_head_idx",    64'(commit_idx),          64'd1);
        chk("exc_head_valid",  64'(commit_valid),        64'd1);
        chk("exc_head_pc",     64'(commit_entry.pc),     64'h304);
        chk("exc_head_status", 64'(commit_entry.status), 64'(EXCEPTION));
        step(0, 1, mk(32'h400, 32'h404), 0, 0, DONE, 1); // faulting retire + alloc
        chk("flush_pulse",     64'(flush),       64'd1);
        chk("flush_redirect",  64'(redirect_pc), 64'h8000_0000);
        chk("flush_count",     64'(count),       64'd0);
        chk("flush_empty",     64'(empty),       64'd1);
        chk("flush_aready",    64'(alloc_ready), 64'd1);
        chk("flush_aidx",      64'(alloc_idx),   64'd0);
        step(0, 1, mk(32'h500, 32'h504), 0, 0, DONE, 0); // alloc during flush cycle is kept
        chk("postflush_flush", 64'(flush),       64'd0);
        chk("postflush_count", 64'(count),       64'd1);

        // Ignored writebacks
        step(0, 0, mk(0, 0), 1, 2, DONE, 0);           // empty slot
        chk("wb_empty_cv",     64'(commit_valid), 64'd0);
        chk("wb_empty_count",  64'(count),        64'd1);
        step(0, 0, mk(0, 0), 1, 0, DONE, 0);
        chk("wb_done_cv",      64'(commit_valid), 64'd1);
        step(0, 0, mk(0, 0), 1, 0, TRAP, 0);           // second report loses
        chk("wb_second_status",64'(commit_entry.status), 64'(DONE));
        step(0, 0, mk(0, 0), 0, 0, DONE, 1);
        chk("wb_retire_count", 64'(count), 64'd0);
        idle(0);
        chk("wb_no_flush",     64'(flush), 64'd0);

        // Mid-operation reset
        step(0, 1, mk(32'h600, 32'h604), 0, 0, DONE, 0);
        step(0, 1, mk(32'h604, 32'h608), 1, 1, DONE, 0);
        step(0, 1, mk(32'h608, 32'h60C), 0, 0, DONE, 0);
        step(1, 1, mk(32'h60C, 32'h610), 1, 2, DONE, 1);
        check_reset_values();
        idle(1);
        chk("rst_after_cv",    64'(commit_valid), 64'd0);
        chk("rst_after_count", 64'(count),        64'd0);

        // Wrap-around: steady stream with allocate and retire every cycle
        step(1, 0, mk(0, 0), 0, 0, DONE, 0);
        step(0, 1, mk(32'h1000, 32'h1004), 0, 0, DONE, 0);
        step(0, 1, mk(32'h1004, 32'h1008), 1, 0, DONE, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, mk(32'h1000 + 4 * (k + 2), 32'h1004 + 4 * (k + 2)), 1, (k + 1) % N, DONE, 1);
            chk($sformatf("wrap%0d_count", k), 64'(count),           64'd2);
            chk($sformatf("wrap%0d_cidx", k),  64'(commit_idx),      64'((k + 1) % N));
            chk($sformatf("wrap%0d_pc", k),    64'(commit_entry.pc), 64'(32'h1000 + 4 * (k + 1)));
        end
        step(0, 0, mk(0, 0), 1, 9 % N, DONE, 1);
        idle(1);
        chk("wrap_drained", 64'(empty), 64'd1);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 mk($urandom, $urandom), ($urandom_range(0, 9) < 6),
                 int'($urandom_range(0, N - 1)), rand_status(), ($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_buffer.md
# rob_buffer

In-order reorder buffer built on the `rob_pkg::rob_entry` record and `status_t` codes.
- Rename/dispatch allocates one entry per cycle at the tail.
- Execution units mark entries complete by index.
- The commit stage retires one entry per cycle from the head.
- A retiring entry with a non-`DONE` status flushes the whole buffer and emits a redirect PC for the front end.

## Interface
Parameters:
- `ENTRIES`, default `rob_pkg::ROB_ENTRIES` (256): slot count; must be a power of two ≥ 2.
- `IDX_W`, default `$clog2(ENTRIES)`: slot index width.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous reset, active-high.
- `alloc_valid_in` in 1: dispatch offers an entry.
- `alloc_entry_in` in `rob_entry`: entry to enqueue; its `status` field is ignored.
- `alloc_ready_out` out 1: buffer can accept an entry this cycle.
- `alloc_idx_out` out `IDX_W`: slot the next accepted entry will occupy (current tail).
- `wb_valid_in` in 1: completion report.
- `wb_idx_in` in `IDX_W`: slot being completed.
- `wb_status_in` in `status_t`: `DONE`, `EXCEPTION`, `INTERRUPT` or `TRAP`.
- `commit_valid_out` out 1: head entry is ready to retire.
- `commit_entry_out` out `rob_entry`: head entry contents.
- `commit_idx_out` out `IDX_W`: head slot index.
- `commit_ready_in` in 1: commit stage takes the head.
- `flush_out` out 1: one-cycle pulse after a non-`DONE` retire.
- `redirect_pc_out` out `ADDR_BITS`: `next_pc` of the faulting entry; valid while `flush_out` is high.
- `count_out` out `IDX_W+1`: number of occupied slots.
- `empty_out` out 1: `count == 0`.
- `full_out` out 1: `count == ENTRIES`.

## Operation
- **State:**
  - entry array;
  - per-slot `valid` bits;
  - `head` and `tail` pointers of `IDX_W` bits, wrapping modulo `ENTRIES`;
  - `count` of `IDX_W+1` bits;
  - registered `flush_out` and `redirect_pc_out`.
- **Allocate:** fires when `alloc_valid_in && alloc_ready_out`.
  - `alloc_ready_out = !full_out`; there is no same-cycle bypass from a commit.
  - Writes `alloc_entry_in` into slot `tail`, with `status` forced to `ISSUED`.
  - Sets `valid[tail]`, increments `tail` (wrapping `ENTRIES-1 -> 0`) and increments `count`.
- **Writeback:** when `wb_valid_in`, the slot is updated only if `valid[wb_idx_in]` and its `status == ISSUED`; the status becomes `wb_status_in`.
  - A writeback to an invalid slot is ignored silently.
  - A writeback to an already-completed slot is ignored silently; the first report wins.
  - `wb_status_in == ISSUED` is ignored.
- **Commit outputs:** `commit_valid_out = valid[head] && status[head] != ISSUED`, decoded combinationally from registers. `commit_entry_out` and `commit_idx_out` always reflect `head`.
- **Retire:** fires when `commit_valid_out && commit_ready_in`.
  - If status is `DONE`: clear `valid[head]`, increment `head`, decrement `count`.
  - If status is `EXCEPTION`, `INTERRUPT` or `TRAP`, the entry is still handed to the commit stage that cycle, and on the same edge:
    - all `valid` bits clear;
    - `head = tail = 0` and `count = 0`;
    - `flush_out` goes to 1 and `redirect_pc_out` is loaded with the entry's `next_pc`.
- **Simultaneous events:**
  - Allocate and a `DONE` retire in the same cycle: `count` is unchanged, and both pointers advance.
  - Allocate in the same cycle as a flushing retire: the allocation is discarded, because the flush wins.
  - A writeback in the same cycle as a flush is discarded.
  - A writeback targeting `head` in the same cycle it is first seen: it becomes retireable on the next cycle. There is no writeback-to-commit bypass.
- **Pointer rule:** full and empty are distinguished by `count`, never by pointer equality.

## Timing
- **Reset** (synchronous, `rst_in` high at an edge):
  - `head = tail = count = 0`;
  - all `valid` bits 0;
  - `flush_out = 0` and `redirect_pc_out = 0`;
  - therefore `alloc_ready_out = 1`, `empty_out = 1`, `full_out = 0`, `commit_valid_out = 0`, `alloc_idx_out = 0`, `commit_idx_out = 0`.
  - Reset overrides any alloc, writeback or commit in the same cycle.
  - Entry array contents are don't-care after reset.
- **Latencies:**
  - An allocated entry is visible at `head` (if the buffer was empty) on the next cycle.
  - Writeback to visible retireable status takes 1 cycle.
  - A retire takes effect at the edge.
- **Flush timing:**
  - `flush_out` is high for exactly one cycle, the cycle after the faulting retire handshake.
  - During that cycle the buffer is already empty and `alloc_ready_out = 1`.
  - Allocations accepted during that cycle are kept; the front end is responsible for gating them.
- **Throughput:** sustained 1 allocate plus 1 retire per cycle.

## Test plan
Benches use `ENTRIES=4` unless stated otherwise.
- **Fill/drain:**
  - Stimulus: reset, then allocate 4 entries with pc 0x100/0x104/0x108/0x10C.
  - Required: `full_out=1`, `alloc_ready_out=0`, `count_out=4`, `alloc_idx_out` sequence 0,1,2,3.
  - Stimulus: write back `DONE` to all, `commit_ready_in=1`.
  - Required: retires in pc order over 4 consecutive cycles, then `empty_out=1`.
- **Out-of-order completion:**
  - Stimulus: allocate 3 entries; write back idx 2, then idx 1.
  - Required: `commit_valid_out` stays 0 until idx 0 is completed; then it retires 0,1,2 on back-to-back cycles.
- **Wrap-around:**
  - Stimulus: 10 entries streamed with simultaneous allocate and retire each cycle.
  - Required: `count_out` is constant; indices wrap 3→0; no entry is lost or duplicated.
- **Exception flush:**
  - Stimulus: entries at idx 0–2; idx 1 completes with `EXCEPTION` and `next_pc` 0x8000_0000; idx 0 is `DONE`; allocate in the same cycle as the idx 1 retire.
  - Required: idx 1 is presented on `commit_entry_out`; the next cycle `flush_out=1`, `redirect_pc_out=0x8000_0000`, `count_out=0`; the same-cycle allocation is dropped.
- **Ignored writebacks:**
  - Stimulus: writeback `DONE` to an empty slot, and a second writeback (`TRAP`) to an already-`DONE` slot.
  - Required: no state change; the entry retires normally as `DONE`.
- **Mid-operation reset:**
  - Stimulus: `rst_in` pulsed with 3 valid entries while alloc, writeback and commit are all active.
  - Required: all reset values hold the next cycle and no retire occurs.
